// File: rtl/decrementer.sv
// Loadable down-counter with a zero flag and a one-cycle underflow pulse.
// Define DECREMENTER_WRAP_EN to wrap to all-ones at zero; by default the count saturates at 0.
module decrementer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] initial_value,
  input  logic             load,
  input  logic             decrement,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             underflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  // Load beats decrement; initial_value is only looked at when loading.
  always_comb begin
    count_d     = count_q;
    underflow_d = 1'b0;
    if (load) begin
      count_d = initial_value;
    end else if (decrement) begin
      if (count_q == '0) begin
        underflow_d = 1'b1;
`ifdef DECREMENTER_WRAP_EN
        count_d     = '1;
`else
        count_d     = '0;
`endif
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign zero      = (count_q == '0);
  assign underflow = underflow_q;

endmodule

// File: tb/tb_decrementer.sv
// Directed bench for decrementer: a behavioural model checked every cycle plus literal expectations.
module tb_decrementer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, load, decrement;
  logic [W-1:0] initial_value;
  logic [W-1:0] count;
  logic         zero, underflow;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

`ifdef DECREMENTER_WRAP_EN
  localparam int AT_ZERO = 15;
`else
  localparam int AT_ZERO = 0;
`endif

  // Model: count as an integer in 0..2^W-1, underflow as a flag.
  int exp_cnt = 0;
  bit exp_uf  = 1'b0;

  decrementer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .initial_value(initial_value), .load(load),
    .decrement(decrement), .count(count), .zero(zero), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      exp_cnt <= 0;
      exp_uf  <= 1'b0;
    end else if (load) begin
      exp_cnt <= int'(initial_value);
      exp_uf  <= 1'b0;
    end else if (decrement && exp_cnt == 0) begin
      exp_cnt <= AT_ZERO;
      exp_uf  <= 1'b1;
    end else if (decrement) begin
      exp_cnt <= (exp_cnt - 1) % (1 << W);
      exp_uf  <= 1'b0;
    end else begin
      exp_uf  <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_count", 32'(count), 32'(exp_cnt));
      chk("model_zero", 32'(zero), 32'(exp_cnt == 0));
      chk("model_underflow", 32'(underflow), 32'(exp_uf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset overrides a simultaneous load of 9.
    reset = 1'b1; load = 1'b1; initial_value = 4'd9; decrement = 1'b0;
    step();
    chk("reset_count", 32'(count), 0);
    chk("reset_zero", 32'(zero), 1);
    chk("reset_underflow", 32'(underflow), 0);
    checking = 1'b1;

    // Load priority over a one-cycle decrement pulse.
    reset = 1'b0; load = 1'b1; initial_value = 4'd3;
    step();
    chk("load_count", 32'(count), 3);
    decrement = 1'b1;
    step();
    chk("load_prio_count", 32'(count), 3);
    decrement = 1'b0;
    step();
    chk("load_after_count", 32'(count), 3);

    // Countdown 3 -> 2 -> 1 -> 0.
    load = 1'b0; decrement = 1'b1;
    step(); chk("cd_2", 32'(count), 2);
    step(); chk("cd_1", 32'(count), 1);
    step(); chk("cd_0", 32'(count), 0);
    chk("cd_zero", 32'(zero), 1);
    chk("cd_no_uf", 32'(underflow), 0);

    // Decrement at zero.
    step();
    chk("uf_pulse", 32'(underflow), 1);
    chk("uf_count", 32'(count), AT_ZERO);
    decrement = 1'b0;
    step();
    chk("uf_clear", 32'(underflow), 0);
    chk("uf_count_hold", 32'(count), AT_ZERO);

    // Hold at 5 for 20 cycles; X on initial_value must be ignored while not loading.
    load = 1'b1; initial_value = 4'd5;
    step();
    load = 1'b0; initial_value = 4'bxxxx;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_count", 32'(count), 5);
      chk("hold_uf", 32'(underflow), 0);
    end

    // Load together with decrement at count 0 gives no underflow.
    load = 1'b1; initial_value = 4'd0;
    step();
    decrement = 1'b1;
    initial_value = 4'd7;
    step();
    chk("load_at0_count", 32'(count), 7);
    chk("load_at0_uf", 32'(underflow), 0);

    // Reset mid-countdown from 12 on the third decrement edge.
    decrement = 1'b0; initial_value = 4'd12;
    step();
    load = 1'b0; decrement = 1'b1;
    step(); chk("rst_mid_11", 32'(count), 11);
    step(); chk("rst_mid_10", 32'(count), 10);
    reset = 1'b1;
    step();
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_uf", 32'(underflow), 0);
    reset = 1'b0;
    step();
    chk("rst_resume_count", 32'(count), AT_ZERO);
    chk("rst_resume_uf", 32'(underflow), 1);
    step();
    chk("rst_resume2_count", 32'(count), (AT_ZERO == 0) ? 0 : 14);
    chk("rst_resume2_uf", 32'(underflow), (AT_ZERO == 0) ? 1 : 0);
    decrement = 1'b0;
    step();
    step();

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decrementer.md
DECREMENTER -- requirements
Module: decrementer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of initial_value and count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port initial_value, input, WIDTH bits: value loaded into the counter.
REQ-005 The block SHALL have port load, input, 1 bit: level-sensitive load request, sampled each rising edge.
REQ-006 The block SHALL have port decrement, input, 1 bit: level-sensitive decrement request, sampled each rising edge.
REQ-007 The block SHALL have port count, output, WIDTH bits: registered counter value.
REQ-008 The block SHALL have port zero, output, 1 bit: high exactly when count equals 0; combinational decode of the count register.
REQ-009 The block SHALL have port underflow, output, 1 bit: registered one-cycle pulse marking a decrement accepted while count was 0.

Function
REQ-010 Per rising edge, the counter SHALL apply this priority: reset, then load, then decrement, then hold.
REQ-011 load=1 SHALL set count to initial_value one cycle later, regardless of decrement; underflow goes to 0.
REQ-012 load=0 and decrement=1 with count>0 SHALL set count to count-1 one cycle later, modulo 2^WIDTH; underflow goes to 0.
REQ-013 load=0 and decrement=1 with count=0 SHALL set underflow to 1 for exactly the next cycle; the count result is defined by REQ-020/REQ-021.
REQ-014 load=0 and decrement=0 SHALL hold count unchanged; underflow goes to 0.
REQ-015 decrement held high SHALL decrement once per cycle; no edge detection is applied.
REQ-016 X/unknown initial_value SHALL only propagate to count when load=1; initial_value is otherwise ignored.
REQ-017 Latency from any accepted command to the updated count SHALL be one clock cycle; no handshake or back-pressure exists.

Reset
REQ-018 reset=1 at a rising edge SHALL set count to 0 and underflow to 0, overriding load and decrement; zero then reads 1.
REQ-019 Deasserting reset SHALL resume normal operation on the next rising edge; reset asserted mid-count SHALL abort immediately with no other side effects.

Configuration
REQ-020 With macro DECREMENTER_WRAP_EN defined, a decrement at count=0 SHALL wrap count to 2^WIDTH-1 (15 for WIDTH=4) and pulse underflow.
REQ-021 Without DECREMENTER_WRAP_EN, a decrement at count=0 SHALL saturate: count stays 0 and underflow still pulses.

Verification
REQ-022 Reset: reset=1 for one edge with load=1, initial_value=9 -> count=0, zero=1, underflow=0.
REQ-023 Load priority: load=1, initial_value=3, decrement pulsed for one cycle while load stays high -> count=3 throughout.
REQ-024 Countdown: load 3, then load=0, decrement=1 for 3 cycles -> count 2,1,0; zero=1 after the third edge; underflow stays 0.
REQ-025 Underflow: from count=0 apply decrement=1 for one cycle -> underflow=1 for one cycle; count=15 with DECREMENTER_WRAP_EN, count=0 without it.
REQ-026 Hold: load 5, then load=0, decrement=0 for 20 cycles -> count stays 5 and underflow stays 0.
REQ-027 Reset mid-countdown: load 12, then decrement=1 with reset=1 on the third edge -> count=0 on that edge; counting resumes from 0 when reset is deasserted.
